bus_control_sequencer: RTL
==========================

// Module: bus_control_sequencer
// PURPOSE
//  Initiator side of the register control interface. Drives the per-register load
//  triggers and active-low bus-assert strobes that the GPR file (A,B,X,Q) responds to.
//  Fetches instruction bytes from program ROM over dbus, decodes them, then sequences
//  one bus transfer or jump per instruction. Sits between the ROM/PC and the register file.
// PARAMETERS
//  PC_W      8      program counter width; pc wraps modulo 2**PC_W
//  HALT_OP   8'hFF  opcode that stops the sequencer until reset
// PORTS
//  clkBar      in   1  clock, one clock; all state updates on rising edge of clkBar
//  resetBar    in   1  reset, asynchronous, active-low
//  dbus        in   8  shared data bus; read only (IR, immediates, jump targets)
//  aluZero     in   1  ALU zero flag, sampled in EXEC/IMM of a conditional jump
//  pc          out  PC_W  ROM address for the current fetch/immediate byte
//  ir          out  8  latched instruction register
//  triggerA/B/X/Q out 1 each  active-high load strobe to register A/B/X/Q
//  assertBarA/X   out 1 each  active-low drive enable for A/X onto dbus
//  assertBarRom   out 1  active-low ROM output enable
//  assertBarAlu   out 1  active-low ALU output enable
//  halted      out  1  high while in HALT
// BEHAVIOUR
//  Opcode: ir[7:6] src 00=ROM immediate(next byte),01=A,10=X,11=ALU; ir[5:4] dst
//   00=A,01=B,10=X,11=Q; ir[3] jump (dst ignored, target is pc); ir[2] conditional
//   (jump only if aluZero=1); ir[1:0] reserved, treated as don't-care. ir==HALT_OP -> halt.
//  States: FETCH, EXEC, IMM, HALT (2-bit encoded).
//   FETCH: assertBarRom=0; at edge ir<=dbus, pc<=pc+1; next = HALT if dbus==HALT_OP,
//          IMM if dbus[7:6]==00, else EXEC.
//   EXEC : assert src (A/X/ALU), trigger dst; jump with non-ROM src loads pc<=dbus if
//          taken else no pc change; next FETCH.
//   IMM  : assertBarRom=0; non-jump: trigger dst, pc<=pc+1; jump taken: pc<=dbus;
//          jump not taken: pc<=pc+1 (skip target byte); next FETCH.
//   HALT : all strobes inactive, pc frozen, halted=1; leaves only via reset.
//  Strobes are Moore outputs of (state, ir) only; never depend on dbus combinationally.
//  Exactly one assertBar* low in FETCH/EXEC/IMM; none low in HALT or during reset.
//  At most one trigger high per cycle; triggers never high in FETCH or HALT.
//  Jumps never raise a register trigger.
//  Self-transfer (src A -> dst A) is legal: assertBarA=0 and triggerA=1 same cycle.
//  pc increment wraps 2**PC_W-1 -> 0 without side effects.
//  Reset (async, any state, mid-instruction): state=FETCH, pc=0, ir=0, halted=0,
//   all triggers 0, all assertBar* 1 while resetBar=0; first fetch on first edge after release.
//  Instruction latency: 2 cycles (register src) or 2 cycles (immediate), 1 cycle halt entry.
// STRUCTURE
//  Shared header: opcode field positions, src/dst codes, HALT_OP, state encodings,
//   and the controlBits bundle bit order used by the register file.
//  One sub-module natural: seq_decode (combinational ir+state -> strobe vector).
//  PC counter and state register live in the top module.
// TESTING
//  Reset then ROM{0x00 0x42}: FETCH pc0, IMM triggerA with dbus=0x42 -> pc=2, A=0x42.
//  ROM{0x50}(A->B): EXEC assertBarA=0, triggerB=1 same cycle; pc=1 after, 2 cycles total.
//  ROM{0x0C 0x80} aluZero=0: no pc load, pc=2; aluZero=1: pc=0x80, no trigger fires.
//  pc=0xFF fetch of 0x40 (A->A): pc wraps to 0x00; assertBarA and triggerA both active.
//  ROM{0xFF}: halted=1 after 1 cycle, all strobes inactive, pc frozen for 20 cycles.
//  resetBar pulsed low mid-IMM: strobes inactive immediately (async), pc=0, refetch pc0.

Source files
------------

// File: rtl/bus_control_sequencer_pkg.sv
// Shared definitions for the bus control sequencer: opcode fields, src/dst codes,
// state encoding and the control-bit bundle seen by the register file.
package bus_control_sequencer_pkg;

  localparam int unsigned SrcMsb  = 7;
  localparam int unsigned SrcLsb  = 6;
  localparam int unsigned DstMsb  = 5;
  localparam int unsigned DstLsb  = 4;
  localparam int unsigned JumpBit = 3;
  localparam int unsigned CondBit = 2;

  localparam logic [7:0] HaltOpDefault = 8'hFF;

  typedef enum logic [1:0] {
    SrcRom = 2'b00,
    SrcA   = 2'b01,
    SrcX   = 2'b10,
    SrcAlu = 2'b11
  } src_e;

  typedef enum logic [1:0] {
    DstA = 2'b00,
    DstB = 2'b01,
    DstX = 2'b10,
    DstQ = 2'b11
  } dst_e;

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StExec  = 2'b01,
    StImm   = 2'b10,
    StHalt  = 2'b11
  } state_e;

  // Bit order matches the register-file control bundle, MSB first.
  typedef struct packed {
    logic trigger_a;
    logic trigger_b;
    logic trigger_x;
    logic trigger_q;
    logic assert_bar_a;
    logic assert_bar_x;
    logic assert_bar_rom;
    logic assert_bar_alu;
  } ctrl_t;

  localparam ctrl_t CtrlIdle = 8'b0000_1111;

  function automatic src_e get_src(input logic [7:0] ir);
    return src_e'(ir[SrcMsb:SrcLsb]);
  endfunction

  function automatic dst_e get_dst(input logic [7:0] ir);
    return dst_e'(ir[DstMsb:DstLsb]);
  endfunction

  function automatic logic is_jump(input logic [7:0] ir);
    return ir[JumpBit];
  endfunction

  function automatic logic jump_taken(input logic [7:0] ir, input logic alu_zero);
    return !ir[CondBit] || alu_zero;
  endfunction

endpackage

// File: rtl/bus_control_sequencer_seq_decode.sv
// Combinational decode of (state, ir) into the trigger / assert-bar strobe bundle.
// Purely Moore: the data bus never reaches these outputs.
module bus_control_sequencer_seq_decode
  import bus_control_sequencer_pkg::*;
(
  input  logic [1:0] state_i,
  input  logic [7:0] ir_i,
  output logic [7:0] ctrl_o
);

  ctrl_t ctrl;
  logic  trig_en;
  logic  unused_ir;

  assign unused_ir = ^ir_i[2:0];

  always_comb begin
    ctrl    = CtrlIdle;
    trig_en = 1'b0;
    unique case (state_e'(state_i))
      StFetch: ctrl.assert_bar_rom = 1'b0;
      StExec: begin
        unique case (get_src(ir_i))
          // Immediates are routed through StImm; kept so one source is always driven.
          SrcRom: ctrl.assert_bar_rom = 1'b0;
          SrcA:   ctrl.assert_bar_a   = 1'b0;
          SrcX:   ctrl.assert_bar_x   = 1'b0;
          SrcAlu: ctrl.assert_bar_alu = 1'b0;
          default: ctrl.assert_bar_rom = 1'b0;
        endcase
        trig_en = !is_jump(ir_i);
      end
      StImm: begin
        ctrl.assert_bar_rom = 1'b0;
        trig_en             = !is_jump(ir_i);
      end
      StHalt:  ctrl = CtrlIdle;
      default: ctrl = CtrlIdle;
    endcase

    if (trig_en) begin
      unique case (get_dst(ir_i))
        DstA:    ctrl.trigger_a = 1'b1;
        DstB:    ctrl.trigger_b = 1'b1;
        DstX:    ctrl.trigger_x = 1'b1;
        DstQ:    ctrl.trigger_q = 1'b1;
        default: ctrl.trigger_a = 1'b0;
      endcase
    end
  end

  assign ctrl_o = ctrl;

endmodule

// File: rtl/bus_control_sequencer.sv
// Fetch/decode/execute sequencer driving register load triggers and bus strobes.
// Holds the program counter, instruction register and state register.
module bus_control_sequencer
  import bus_control_sequencer_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter logic [7:0]  HALT_OP = HaltOpDefault
) (
  input  logic            clkBar,
  input  logic            resetBar,
  input  logic [7:0]      dbus,
  input  logic            aluZero,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      ir,
  output logic            triggerA,
  output logic            triggerB,
  output logic            triggerX,
  output logic            triggerQ,
  output logic            assertBarA,
  output logic            assertBarX,
  output logic            assertBarRom,
  output logic            assertBarAlu,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            take_jump;
  ctrl_t           ctrl;
  ctrl_t           ctrl_out;

  assign take_jump = is_jump(ir_q) && jump_taken(ir_q, aluZero);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StFetch: begin
        ir_d = dbus;
        pc_d = pc_q + PC_W'(1);
        if (dbus == HALT_OP) begin
          state_d = StHalt;
        end else if (get_src(dbus) == SrcRom) begin
          state_d = StImm;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (take_jump) pc_d = PC_W'(dbus);
        state_d = StFetch;
      end
      StImm: begin
        // A not-taken jump still steps over its target byte.
        pc_d    = take_jump ? PC_W'(dbus) : pc_q + PC_W'(1);
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clkBar or negedge resetBar) begin
    if (!resetBar) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  bus_control_sequencer_seq_decode u_decode (
    .state_i (state_q),
    .ir_i    (ir_q),
    .ctrl_o  (ctrl)
  );

  // Reset forces every strobe inactive without waiting for a clock edge.
  assign ctrl_out = resetBar ? ctrl : CtrlIdle;

  assign triggerA     = ctrl_out.trigger_a;
  assign triggerB     = ctrl_out.trigger_b;
  assign triggerX     = ctrl_out.trigger_x;
  assign triggerQ     = ctrl_out.trigger_q;
  assign assertBarA   = ctrl_out.assert_bar_a;
  assign assertBarX   = ctrl_out.assert_bar_x;
  assign assertBarRom = ctrl_out.assert_bar_rom;
  assign assertBarAlu = ctrl_out.assert_bar_alu;

  assign pc     = pc_q;
  assign ir     = ir_q;
  assign halted = (state_q == StHalt);

endmodule
